// File: rtl/x_host_pkg.sv
// Shared types and command encodings for the delay-line byte protocol host sequencer.
package x_host_pkg;

    // Requester operation codes
    typedef enum logic [1:0] {
        OP_WRITE    = 2'd0,
        OP_CAPTURE  = 2'd1,
        OP_READ     = 2'd2,
        OP_CAP_READ = 2'd3
    } op_e;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        StIdle,
        StTxLoad,
        StTxStart,
        StTxUnload,
        StRxWait,
        StRsp
    } state_e;

    // Command byte encodings understood by the delay-line driver
    localparam logic [3:0] CMD_LOAD   = 4'h0;
    localparam logic [7:0] CMD_UNLOAD = 8'h01;
    localparam logic [7:0] CMD_START  = 8'h02;

    // LOAD byte carrying nibble idx of word, counted from the MSB end (idx 0 = word[31:28])
    function automatic logic [7:0] load_byte(input logic [31:0] word, input logic [2:0] idx);
        logic [31:0] shifted;
        shifted = word << {idx, 2'b00};
        return {shifted[31:28], CMD_LOAD};
    endfunction

endpackage

// File: rtl/x_host_seq.sv
// Command initiator for the delay-line byte protocol: turns word requests into the
// command-byte stream for the driver and assembles returned bytes into 32-bit responses.
// Optional feature: define X_HOST_TIMEOUT_EN to build the RX watchdog (TIMEOUT_W bits)
// that aborts a stalled read with o_rsp_err.
module x_host_seq
    import x_host_pkg::*;
#(
    parameter int unsigned TIMEOUT_W = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [1:0]  i_req_op,
    input  logic [31:0] i_req_wdata,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic [7:0]  o_tx_data,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    output logic        o_rx_accept,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_data,
    output logic        o_rsp_err,
    output logic        o_busy
);

    state_e      state_q;
    op_e         op_q;
    logic [31:0] wdata_q;
    logic [2:0]  nib_q;
    logic [1:0]  byte_q;
    logic [31:0] shift_q;
    logic        req_ready_q;
    logic        tx_valid_q;
    logic [7:0]  tx_data_q;
    logic        rsp_valid_q;

`ifdef X_HOST_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wd_q;
    logic                 rsp_err_q;
`else
    // Keeps the parameter referenced when the watchdog is not built
    logic unused_timeout_w;
    assign unused_timeout_w = ^TIMEOUT_W;
`endif

    // Sequencer FSM with registered request/tx/response outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= StIdle;
            op_q        <= OP_WRITE;
            wdata_q     <= '0;
            nib_q       <= '0;
            byte_q      <= '0;
            shift_q     <= '0;
            req_ready_q <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            rsp_valid_q <= 1'b0;
`ifdef X_HOST_TIMEOUT_EN
            wd_q        <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    // ready is registered so it reads 0 straight out of reset
                    req_ready_q <= 1'b1;
                    if (i_req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        op_q        <= op_e'(i_req_op);
                        wdata_q     <= i_req_wdata;
                        nib_q       <= '0;
                        byte_q      <= '0;
                        shift_q     <= '0;
                        tx_valid_q  <= 1'b1;
                        case (op_e'(i_req_op))
                            OP_WRITE: begin
                                state_q   <= StTxLoad;
                                tx_data_q <= load_byte(i_req_wdata, 3'd0);
                            end
                            OP_READ: begin
                                state_q   <= StTxUnload;
                                tx_data_q <= CMD_UNLOAD;
                            end
                            default: begin
                                state_q   <= StTxStart;
                                tx_data_q <= CMD_START;
                            end
                        endcase
                    end
                end

                StTxLoad: begin
                    if (tx_valid_q && i_tx_ready) begin
                        if (nib_q == 3'd7) begin
                            tx_valid_q  <= 1'b0;
                            tx_data_q   <= '0;
                            rsp_valid_q <= 1'b1;
                            state_q     <= StRsp;
                        end else begin
                            nib_q     <= nib_q + 3'd1;
                            tx_data_q <= load_byte(wdata_q, nib_q + 3'd1);
                        end
                    end
                end

                StTxStart: begin
                    if (tx_valid_q && i_tx_ready) begin
                        if (op_q == OP_CAP_READ) begin
                            tx_data_q <= CMD_UNLOAD;
                            state_q   <= StTxUnload;
                        end else begin
                            tx_valid_q  <= 1'b0;
                            tx_data_q   <= '0;
                            rsp_valid_q <= 1'b1;
                            state_q     <= StRsp;
                        end
                    end
                end

                StTxUnload: begin
                    if (tx_valid_q && i_tx_ready) begin
                        tx_valid_q <= 1'b0;
                        tx_data_q  <= '0;
                        state_q    <= StRxWait;
`ifdef X_HOST_TIMEOUT_EN
                        wd_q       <= '0;
`endif
                    end
                end

                StRxWait: begin
                    // MSB byte arrives first, so shift left one byte per pop
                    if (i_rx_valid) begin
                        shift_q <= {shift_q[23:0], i_rx_data};
                        byte_q  <= byte_q + 2'd1;
                        if (byte_q == 2'd3) begin
                            rsp_valid_q <= 1'b1;
                            state_q     <= StRsp;
                        end else begin
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= CMD_UNLOAD;
                            state_q    <= StTxUnload;
                        end
                    end
`ifdef X_HOST_TIMEOUT_EN
                    else if (wd_q == {TIMEOUT_W{1'b1}}) begin
                        // abort with whatever bytes were collected
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        state_q     <= StRsp;
                    end else begin
                        wd_q <= wd_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
                    end
`endif
                end

                StRsp: begin
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    shift_q     <= '0;
                    state_q     <= StIdle;
`ifdef X_HOST_TIMEOUT_EN
                    rsp_err_q   <= 1'b0;
`endif
                end

                default: begin
                    tx_valid_q  <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    // Output drive; the rx pop is combinational so the byte is taken in the cycle it shows
    always_comb begin
        o_req_ready = req_ready_q;
        o_tx_valid  = tx_valid_q;
        o_tx_data   = tx_data_q;
        o_rx_accept = (state_q == StRxWait) && i_rx_valid;
        o_rsp_valid = rsp_valid_q;
        // shift_q is cleared on accept, so WRITE/CAPTURE report zero
        o_rsp_data  = rsp_valid_q ? shift_q : 32'h0;
        o_busy      = (state_q != StIdle);
`ifdef X_HOST_TIMEOUT_EN
        o_rsp_err   = rsp_err_q;
`else
        o_rsp_err   = 1'b0;
`endif
    end

    // A stalled command byte must stay put until the driver takes it
    a_tx_stable: assert property (@(posedge i_clk) disable iff (i_rst)
        (o_tx_valid && !i_tx_ready) |=> (o_tx_valid && $stable(o_tx_data)));

    // Only one UNLOAD outstanding: never pop while a command byte is pending
    a_rx_order: assert property (@(posedge i_clk) disable iff (i_rst)
        o_rx_accept |-> !o_tx_valid);

endmodule

// File: tb/tb_x_host_seq.sv
// Scoreboard bench for x_host_seq: stimulus pushes expected tx bytes and responses,
// a negedge monitor pops and compares; a small driver model answers UNLOAD bytes.
module tb_x_host_seq;

`ifdef X_HOST_TIMEOUT_EN
    localparam int unsigned TB_TW = 4;
`else
    localparam int unsigned TB_TW = 16;
`endif

    logic        i_clk;
    logic        i_rst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [1:0]  i_req_op;
    logic [31:0] i_req_wdata;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic [7:0]  o_tx_data;
    logic        i_rx_valid;
    logic [7:0]  i_rx_data;
    logic        o_rx_accept;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_data;
    logic        o_rsp_err;
    logic        o_busy;

    x_host_seq #(.TIMEOUT_W(TB_TW)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_op    (i_req_op),
        .i_req_wdata (i_req_wdata),
        .o_tx_valid  (o_tx_valid),
        .i_tx_ready  (i_tx_ready),
        .o_tx_data   (o_tx_data),
        .i_rx_valid  (i_rx_valid),
        .i_rx_data   (i_rx_data),
        .o_rx_accept (o_rx_accept),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_data  (o_rsp_data),
        .o_rsp_err   (o_rsp_err),
        .o_busy      (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;

    logic [7:0]  exp_tx[$];
    logic [32:0] exp_rsp[$];   // {err, data}
    logic [7:0]  rx_q[$];

    int   unload_cnt = 0;
    int   accept_cnt = 0;
    bit   rx_pop_seen = 0;
    bit   drv_en = 1;
    bit   rand_rdy = 0;
    bit   stall_q = 0;
    logic [7:0] stall_byte = 8'h00;

    // Monitor: compares every tx handshake and response against the scoreboard
    initial begin : monitor
        logic [7:0]  e8;
        logic [32:0] e33;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                stall_q = 0;
            end else begin
                if (stall_q) begin
                    checks++;
                    if (!o_tx_valid || o_tx_data != stall_byte) begin
                        errors++;
                        $display("FAIL tx_stall: got valid=%0b data=%02h, want valid=1 data=%02h",
                                 o_tx_valid, o_tx_data, stall_byte);
                    end
                end
                stall_q    = o_tx_valid && !i_tx_ready;
                stall_byte = o_tx_data;
                if (o_tx_valid && i_tx_ready) begin
                    checks++;
                    if (exp_tx.size() == 0) begin
                        errors++;
                        $display("FAIL tx_unexpected: got %02h, want no byte", o_tx_data);
                    end else begin
                        e8 = exp_tx.pop_front();
                        if (o_tx_data != e8) begin
                            errors++;
                            $display("FAIL tx_byte: got %02h, want %02h", o_tx_data, e8);
                        end
                    end
                    if (o_tx_data == 8'h01) unload_cnt++;
                end
                if (o_rx_accept) begin
                    rx_pop_seen = 1;
                    accept_cnt++;
                end
                if (o_rsp_valid) begin
                    checks++;
                    if (exp_rsp.size() == 0) begin
                        errors++;
                        $display("FAIL rsp_unexpected: got err=%0b data=%08h, want none",
                                 o_rsp_err, o_rsp_data);
                    end else begin
                        e33 = exp_rsp.pop_front();
                        if ({o_rsp_err, o_rsp_data} != e33) begin
                            errors++;
                            $display("FAIL rsp: got err=%0b data=%08h, want err=%0b data=%08h",
                                     o_rsp_err, o_rsp_data, e33[32], e33[31:0]);
                        end
                    end
                end
            end
        end
    end

    // Driver model: one returned byte per UNLOAD seen, held until popped
    initial begin : driver
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
        forever begin
            @(posedge i_clk);
            #1;
            if (drv_en && !i_rst) begin
                if (i_rx_valid && rx_pop_seen) begin
                    i_rx_valid  = 1'b0;
                    rx_pop_seen = 0;
                end
                if (!i_rx_valid && unload_cnt > 0 && rx_q.size() > 0) begin
                    unload_cnt--;
                    i_rx_valid = 1'b1;
                    i_rx_data  = rx_q.pop_front();
                end
            end
        end
    end

    // Random tx back-pressure when enabled
    initial begin : ready_gen
        forever begin
            @(posedge i_clk);
            #1;
            if (rand_rdy) i_tx_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic check_zero(input string name);
        logic [45:0] v;
        v = {o_req_ready, o_tx_valid, o_tx_data, o_rx_accept, o_rsp_valid, o_rsp_data,
             o_rsp_err, o_busy};
        checks++;
        if (v != 46'h0) begin
            errors++;
            $display("FAIL %s: got outputs=%012h, want 0", name, v);
        end
    endtask

    task automatic do_req(input logic [1:0] op, input logic [31:0] wd);
        int n;
        n = 0;
        @(posedge i_clk);
        #1;
        i_req_valid = 1'b1;
        i_req_op    = op;
        i_req_wdata = wd;
        @(negedge i_clk);
        while (!o_req_ready && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        if (!o_req_ready) begin
            errors++;
            $display("FAIL req_accept: got ready=0 after %0d cycles, want 1", n);
        end
        @(posedge i_clk);
        #1;
        i_req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        @(negedge i_clk);
        while ((exp_rsp.size() != 0 || o_busy) && n < 1000) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        if (exp_rsp.size() != 0 || o_busy) begin
            errors++;
            $display("FAIL %s_done: got busy=%0b pending=%0d, want idle with 0 pending",
                     name, o_busy, exp_rsp.size());
        end
    endtask

    task automatic push_tx(input logic [7:0] b);
        exp_tx.push_back(b);
    endtask

    task automatic push_word_rx(input logic [31:0] w);
        rx_q.push_back(w[31:24]);
        rx_q.push_back(w[23:16]);
        rx_q.push_back(w[15:8]);
        rx_q.push_back(w[7:0]);
    endtask

    initial begin : bound
        #300000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1, "bench time limit");
    end

    initial begin : stim
        logic [7:0] wr1 [8];
        logic [7:0] wr4 [8];
        logic [7:0] wr5 [8];
        wr1 = '{8'hD0, 8'hE0, 8'hA0, 8'hD0, 8'hB0, 8'hE0, 8'hE0, 8'hF0};
        wr4 = '{8'h50, 8'hA0, 8'h30, 8'hC0, 8'h90, 8'h60, 8'hE0, 8'h10};
        wr5 = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70};

        i_rst       = 1'b1;
        i_req_valid = 1'b0;
        i_req_op    = 2'd0;
        i_req_wdata = 32'h0;
        i_tx_ready  = 1'b1;
        repeat (2) @(posedge i_clk);
        #2;
        check_zero("reset_state");
        i_rst = 1'b0;

        // 1: WRITE 0xDEADBEEF
        foreach (wr1[k]) push_tx(wr1[k]);
        exp_rsp.push_back({1'b0, 32'h0});
        do_req(2'd0, 32'hDEADBEEF);
        wait_done("write");

        // Stray rx in IDLE must not be popped
        drv_en = 0;
        @(posedge i_clk);
        #1;
        i_rx_valid = 1'b1;
        i_rx_data  = 8'h99;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            checks++;
            if (o_rx_accept) begin
                errors++;
                $display("FAIL stray_rx: got accept=1, want 0");
            end
        end
        @(posedge i_clk);
        #1;
        i_rx_valid = 1'b0;
        drv_en     = 1;

        // 2: READ 0x12345678
        accept_cnt = 0;
        repeat (4) push_tx(8'h01);
        push_word_rx(32'h12345678);
        exp_rsp.push_back({1'b0, 32'h12345678});
        do_req(2'd2, 32'h0);
        wait_done("read");
        checks++;
        if (accept_cnt != 4) begin
            errors++;
            $display("FAIL read_accepts: got %0d, want 4", accept_cnt);
        end

        // CAPTURE alone
        push_tx(8'h02);
        exp_rsp.push_back({1'b0, 32'h0});
        do_req(2'd1, 32'hFFFFFFFF);
        wait_done("capture");

        // 3: CAPTURE then READ 0xA5A50F0F
        push_tx(8'h02);
        repeat (4) push_tx(8'h01);
        push_word_rx(32'hA5A50F0F);
        exp_rsp.push_back({1'b0, 32'hA5A50F0F});
        do_req(2'd3, 32'h0);
        wait_done("cap_read");

        // 4: random tx back-pressure on WRITE and READ
        rand_rdy = 1;
        foreach (wr4[k]) push_tx(wr4[k]);
        exp_rsp.push_back({1'b0, 32'h0});
        do_req(2'd0, 32'h5A3C96E1);
        wait_done("write_stall");
        repeat (4) push_tx(8'h01);
        push_word_rx(32'hCAFE0001);
        exp_rsp.push_back({1'b0, 32'hCAFE0001});
        do_req(2'd2, 32'h0);
        wait_done("read_stall");
        rand_rdy = 0;
        @(posedge i_clk);
        #1;
        i_tx_ready = 1'b1;

        // 5: reset while the 3rd rx byte of a READ is presented
        accept_cnt = 0;
        repeat (4) push_tx(8'h01);
        push_word_rx(32'h11223344);
        do_req(2'd2, 32'h0);
        begin
            int n;
            n = 0;
            while (!(accept_cnt == 2 && i_rx_valid) && n < 200) begin
                @(posedge i_clk);
                #3;
                n++;
            end
            checks++;
            if (!(accept_cnt == 2 && i_rx_valid)) begin
                errors++;
                $display("FAIL reset_setup: got accepts=%0d rx_valid=%0b, want 2 and 1",
                         accept_cnt, i_rx_valid);
            end
        end
        i_rst = 1'b1;
        #1;
        check_zero("mid_reset");
        drv_en      = 0;
        i_rx_valid  = 1'b0;
        exp_tx.delete();
        exp_rsp.delete();
        rx_q.delete();
        unload_cnt  = 0;
        rx_pop_seen = 0;
        repeat (2) @(posedge i_clk);
        #2;
        i_rst  = 1'b0;
        drv_en = 1;
        foreach (wr5[k]) push_tx(wr5[k]);
        exp_rsp.push_back({1'b0, 32'h0});
        do_req(2'd0, 32'h01234567);
        wait_done("write_after_reset");

`ifdef X_HOST_TIMEOUT_EN
        // 6: READ with no returned byte aborts via the watchdog
        drv_en = 0;
        push_tx(8'h01);
        exp_rsp.push_back({1'b1, 32'h0});
        do_req(2'd2, 32'h0);
        wait_done("timeout");
        drv_en = 1;
`endif

        checks++;
        if (exp_tx.size() != 0 || rx_q.size() != 0) begin
            errors++;
            $display("FAIL leftovers: got tx=%0d rx=%0d pending, want 0",
                     exp_tx.size(), rx_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
